// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_timer peripheral.
//   - register word addresses as seen on the bridge Addr bus
//   - CTRL register bit positions
//   - MODE field encodings
//   - FSM state encoding (also driven onto the timer's debug state port)
package tc_pkg;

    // Register word addresses (processor byte address bits [3:2]).
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL register layout. Bits above CTRL_BITS-1 do not exist.
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_BITS     = 4;

    // MODE field encodings. Any value other than MODE_RELOAD runs one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/tc_timer.sv
// tc_timer: programmable down-counting timer/counter on the processor bridge.
//
// Registers (word address on Addr):
//   0 CTRL   R/W  bit0 EN, bits[2:1] MODE, bit3 IM; upper bits read 0
//   1 PRESET R/W  reload value for COUNT
//   2 COUNT  RO   current count
//   3 -      reads 0
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous active-low reset
//   Addr        register word select
//   WE          register write strobe, sampled on rising clk
//   Din         register write data
//   Dout        register read data, combinational from Addr
//   IRQ         interrupt request = CTRL.IM & irq_flag
//   dbg_state_o current FSM state, for observation only
//
// The bus has no handshake: a write is accepted on every rising edge where
// WE is high, and a read is a pure combinational mux of Addr.
module tc_timer
    import tc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ,
    output tc_state_e        dbg_state_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [CTRL_BITS-1:0] ctrl_q;
    logic [WIDTH-1:0]     preset_q;
    logic [WIDTH-1:0]     count_q;
    logic                 irq_flag_q;
    tc_state_e            state_q;

    logic       wr_ctrl;
    logic       wr_preset;
    logic       en;
    logic [1:0] mode;

    assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign wr_preset = WE && (Addr == ADDR_PRESET);
    assign en        = ctrl_q[CTRL_EN];
    assign mode      = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

    // FSM and register file share one process so that a software write and
    // an FSM update of the same bit resolve in a single place: the register
    // writes come last, so software wins for CTRL bits and for irq_flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q    <= preset_q;
                    // Ends the single-cycle pulse raised by an auto-reload INT.
                    // A sticky one-shot flag can only reach here after a CTRL
                    // write, which clears it anyway.
                    irq_flag_q <= 1'b0;
                    state_q    <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (count_q <= ONE) begin
                        // Covers PRESET=0 as well: never decrement below 0.
                        count_q <= '0;
                        state_q <= INT;
                    end else begin
                        count_q <= count_q - ONE;
                    end
                end
                INT: begin
                    irq_flag_q <= 1'b1;
                    if (mode == MODE_RELOAD) begin
                        state_q <= LOAD;
                    end else begin
                        ctrl_q[CTRL_EN] <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (wr_ctrl) begin
                ctrl_q     <= Din[CTRL_BITS-1:0];
                irq_flag_q <= 1'b0;
            end
            if (wr_preset) begin
                preset_q   <= Din;
                irq_flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            ADDR_CTRL:   Dout = WIDTH'(ctrl_q);
            ADDR_PRESET: Dout = preset_q;
            ADDR_COUNT:  Dout = count_q;
            default:     Dout = '0;
        endcase
    end

    assign IRQ         = ctrl_q[CTRL_IM] & irq_flag_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: self-checking bench for tc_timer.
// Expected {state, IRQ, COUNT} tuples are queued as each scenario is
// started and popped one per clock as the DUT is sampled 1 ns after the edge.
module tb_tc_timer;
    import tc_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   Addr;
    logic         WE;
    logic [W-1:0] Din;
    logic [W-1:0] Dout;
    logic         IRQ;
    tc_state_e    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];

    tc_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Addr       (Addr),
        .WE         (WE),
        .Din        (Din),
        .Dout       (Dout),
        .IRQ        (IRQ),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking / scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input tc_state_e st, input logic irq, input logic [31:0] cnt);
        return {29'd0, st, irq, cnt};
    endfunction

    task automatic push(input tc_state_e st, input logic irq, input logic [31:0] cnt);
        exp_q.push_back(pk(st, irq, cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    // Sample {state, IRQ, COUNT} and compare against the head of the queue.
    task automatic sb_sample(input string tag);
        logic [W-1:0] c;
        logic [63:0]  obs;
        rd(ADDR_COUNT, c);
        obs = pk(dbg_state, IRQ, c);
        if (exp_q.size() == 0) check({tag, "_queue_empty"}, obs, 64'bx);
        else                   check(tag, obs, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] d;
        bit           found;

        reset = 1'b0;
        Addr  = 2'd0;
        WE    = 1'b0;
        Din   = '0;

        // Reset state
        #2;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("reset_dout_a%0d", a), d, 0);
        end
        check("reset_irq", IRQ, 0);
        check("reset_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // One-shot: PRESET=5, CTRL=0x9 at edge t
        wr(ADDR_PRESET, 5);
        wr(ADDR_CTRL, 32'h9);
        for (int k = 0; k < 5; k++) push(CNT, 1'b0, 32'(5 - k));
        push(INT, 1'b0, 0);
        push(IDLE, 1'b1, 0);
        push(IDLE, 1'b1, 0);
        push(IDLE, 1'b1, 0);
        tick();                                   // edge t+1
        for (int k = 0; k < 9; k++) begin         // edges t+2 .. t+10
            tick();
            sb_sample("oneshot_seq");
        end
        rd(ADDR_CTRL, d);
        check("oneshot_ctrl_en_cleared", d, 32'h8);
        wr(ADDR_CTRL, 32'h8);
        check("oneshot_irq_cleared_by_ctrl_write", IRQ, 0);

        // Auto-reload: PRESET=3, CTRL=0xB, three periods of N+2=5
        wr(ADDR_PRESET, 3);
        wr(ADDR_CTRL, 32'hB);
        for (int i = 0; i < 15; i++) begin
            case (i % 5)
                0, 1, 2: push(CNT, 1'b0, 32'(3 - (i % 5)));
                3:       push(INT, 1'b0, 0);
                default: push(LOAD, 1'b1, 0);
            endcase
        end
        tick();                                   // edge t+1
        for (int i = 0; i < 15; i++) begin        // edges t+2 .. t+16
            tick();
            sb_sample("reload_seq");
        end
        wr(ADDR_CTRL, 32'h0);                     // LOAD -> CNT (count 3), EN off
        tick();
        check("reload_stop_state", dbg_state, IDLE);
        rd(ADDR_COUNT, d);
        check("reload_stop_count", d, 3);

        // Mask: PRESET=2, CTRL=0x1 (IM=0)
        wr(ADDR_PRESET, 2);
        wr(ADDR_CTRL, 32'h1);
        push(LOAD, 1'b0, 3);
        push(CNT, 1'b0, 2);
        push(CNT, 1'b0, 1);
        push(INT, 1'b0, 0);
        push(IDLE, 1'b0, 0);
        push(IDLE, 1'b0, 0);
        push(IDLE, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            sb_sample("mask_seq");
        end
        rd(ADDR_CTRL, d);
        check("mask_ctrl_en_cleared", d, 32'h0);
        wr(ADDR_CTRL, 32'h8);                     // set IM; the write clears the flag
        check("mask_irq_after_im_set", IRQ, 0);
        tick();
        check("mask_irq_after_im_set_2", IRQ, 0);

        // Stop and PRESET update mid-count
        wr(ADDR_PRESET, 10);
        wr(ADDR_CTRL, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            rd(ADDR_COUNT, d);
            if (d == 6) found = 1'b1;
        end
        check("stop_reached_count6", found, 1);
        push(CNT, 1'b0, 5);
        push(CNT, 1'b0, 4);
        push(CNT, 1'b0, 3);
        push(CNT, 1'b0, 2);                       // EN clear seen one edge late
        push(IDLE, 1'b0, 2);
        push(IDLE, 1'b0, 2);
        push(IDLE, 1'b0, 2);
        wr(ADDR_PRESET, 2);
        sb_sample("stop_seq");
        tick();
        sb_sample("stop_seq");
        tick();
        sb_sample("stop_seq");
        wr(ADDR_CTRL, 32'h0);
        sb_sample("stop_seq");
        wr(ADDR_COUNT, 32'hDEAD_BEEF);            // read-only
        sb_sample("stop_seq_ro_write");
        wr(2'd3, 32'h1234_5678);                  // unmapped
        sb_sample("stop_seq_unmapped_write");
        tick();
        sb_sample("stop_seq");
        rd(ADDR_PRESET, d);
        check("illegal_wr_preset", d, 2);
        rd(ADDR_CTRL, d);
        check("illegal_wr_ctrl", d, 0);
        rd(2'd3, d);
        check("illegal_wr_addr3", d, 0);

        // Re-enable: reloads the updated PRESET
        wr(ADDR_CTRL, 32'h1);
        push(IDLE, 1'b0, 2);
        push(LOAD, 1'b0, 2);
        push(CNT, 1'b0, 2);
        push(CNT, 1'b0, 1);
        push(INT, 1'b0, 0);
        push(IDLE, 1'b0, 0);
        sb_sample("reenable_seq");
        for (int i = 0; i < 5; i++) begin
            tick();
            sb_sample("reenable_seq");
        end

        // PRESET=0, one-shot with IM: INT two edges after LOAD
        wr(ADDR_PRESET, 0);
        wr(ADDR_CTRL, 32'h9);
        push(LOAD, 1'b0, 0);
        push(CNT, 1'b0, 0);
        push(INT, 1'b0, 0);
        push(IDLE, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            sb_sample("preset0_seq");
        end
        rd(ADDR_CTRL, d);
        check("preset0_ctrl", d, 32'h8);

        // Asynchronous reset with IRQ high and registers loaded
        wr(ADDR_PRESET, 7);
        wr(ADDR_CTRL, 32'h9);
        repeat (10) tick();                       // IRQ after edge t+10
        check("prereset_irq", IRQ, 1);
        reset = 1'b0;
        #1;
        check("async_reset_irq", IRQ, 0);
        check("async_reset_state", dbg_state, IDLE);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("async_reset_dout_a%0d", a), d, 0);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("post_reset_state", dbg_state, IDLE);
        check("post_reset_irq", IRQ, 0);
        rd(ADDR_COUNT, d);
        check("post_reset_count", d, 0);

        check("scoreboard_drained", 64'(exp_q.size()), 0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tc_timer.md
Name: tc_timer

Overview:
- Programmable 32-bit down-counting timer/counter peripheral on the processor bridge; two instances sit beside the CPU.
- Bridge decodes the processor address to this device, forwards word address, write enable and write data, and returns the read data.
- Raises a maskable interrupt request that feeds the CPU hardware-interrupt vector.

Parameters:
- WIDTH, 32, data and counter width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- Addr  input  2  register word select (processor byte address bits [3:2]).
- WE  input  1  register write strobe, sampled on rising clk.
- Din  input  WIDTH  register write data.
- Dout  output  WIDTH  register read data, combinational from Addr.
- IRQ  output  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- Register map:
  - Addr 0 is CTRL, R/W. Bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0, writes ignored.
  - Addr 1 is PRESET, R/W.
  - Addr 2 is COUNT, read-only; writes ignored.
  - Addr 3 reads 0; writes ignored.
- Reset (reset low, asynchronous):
  - CTRL, PRESET, COUNT and irq_flag are cleared to 0.
  - FSM state goes to IDLE.
  - IRQ=0 and Dout=0 for every Addr.
- FSM states are IDLE, LOAD, CNT, INT. Transitions are evaluated on each rising edge:
  - IDLE: if EN=1, go to LOAD; COUNT holds.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE and COUNT holds. Else if COUNT<=1, COUNT<=0 and go to INT. Else COUNT<=COUNT-1.
  - INT, MODE=00 (one-shot): irq_flag<=1, EN<=0, go to IDLE. irq_flag stays 1 until any write to CTRL or PRESET clears it.
  - INT, MODE=01 (auto-reload): irq_flag<=1 for exactly one cycle (cleared on the next edge), go to LOAD. EN is unchanged.
  - MODE=10 and MODE=11 behave as MODE=00.
- Latency:
  - A CTRL write that sets EN at edge t gives COUNT=PRESET after edge t+2.
  - With PRESET=N>=1, COUNT reaches 0 and the FSM enters INT at edge t+2+N. IRQ is visible after edge t+3+N.
  - Auto-reload period is N+2 cycles between successive IRQ pulses.
- PRESET=0 or PRESET=1: LOAD then INT on the following edge.
- Register write timing:
  - A write to PRESET during CNT does not disturb the current count; the new value takes effect at the next LOAD.
  - A write to CTRL takes effect at the same edge. If EN is cleared during CNT, the FSM goes to IDLE on the next edge with COUNT frozen.
- Simultaneous events:
  - A software CTRL write in the same cycle as the INT-state EN clear: the software write wins for CTRL bits.
  - That same write also clears irq_flag, so irq_flag ends at 0.
- Reset asserted mid-count: immediate return to the reset values; no IRQ glitch.
- Arithmetic is unsigned and WIDTH-bit. No wrap: COUNT never decrements below 0.

Decomposition:
- Shared package tc_pkg holds:
  - address constants (ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2);
  - CTRL bit positions (EN=0, MODE_LSB=1, MODE_MSB=2, IM=3);
  - mode encodings (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01);
  - the FSM state enum (IDLE, LOAD, CNT, INT).
- Single flat module; no sub-module. The read mux is small enough to stay inline.

Test Plan:
- Reset: pulse reset low mid-simulation -> Dout reads 0 at Addr 0..3 and IRQ=0 within the same cycle, without waiting for a clock edge.
- One-shot:
  - Stimulus: PRESET=5, then CTRL=0x9 (EN, IM, mode 0) at edge t.
  - COUNT reads 5,4,3,2,1,0 after edges t+2..t+7.
  - IRQ rises after edge t+8 and stays high; CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ one-cycle pulses every 5 cycles; COUNT cycles 3,2,1,0 with reload. Repeat for at least 3 periods.
- Mask: PRESET=2, CTRL=0x1 (IM=0) -> irq_flag set but IRQ stays 0. Setting IM by writing CTRL=0x8 clears the flag, so IRQ stays 0.
- Stop and PRESET update mid-count:
  - Stimulus: PRESET=10, enable, wait until COUNT=6, write PRESET=2.
  - Required: COUNT continues 5,4,... without disturbance.
  - Then clear EN at COUNT=3: COUNT freezes at 3 or 2 per the one-edge latency.
  - Re-enable: COUNT reloads to 2.
- Edge values and illegal writes:
  - PRESET=0 with mode 0 -> INT two edges after LOAD, IRQ asserted.
  - Writes to Addr 2 and Addr 3 leave COUNT and all reads unchanged.
